bomb_sequencer: RTL and testbench

BOMB_SEQUENCER -- requirements
Module: bomb_sequencer

---
 rtl/bomb_sequencer.sv | 163 ++++++++++++++++
 tb/tb_bomb_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bomb_sequencer.sv
// Bomb sequencer: drives the control codes of an external countdown timer
// register and an external secret-code register, tracks wrong code entries
// and reports IDLE/SET/ARMED/DEFUSED/EXPLODED.
module bomb_sequencer #(
  parameter int unsigned TIMER_WIDTH = 8,
  parameter int unsigned CODE_WIDTH  = 4,
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned MAX_TRIES   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   set_up,
  input  logic                   set_down,
  input  logic                   arm,
  input  logic [CODE_WIDTH-1:0]  code_in,
  input  logic                   code_valid,
  input  logic [TIMER_WIDTH-1:0] timer_value,
  input  logic [CODE_WIDTH-1:0]  secret_value,
  output logic [2:0]             timer_ctrl,
  output logic [2:0]             secret_ctrl,
  output logic [2:0]             state,
  output logic                   tick,
  output logic [1:0]             tries_left
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned WR_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned REM_W = (WR_W > 2) ? WR_W : 2;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [WR_W-1:0]  WR_MAX   = WR_W'(MAX_TRIES);

  localparam logic [2:0] CTRL_NONE = 3'd0;
  localparam logic [2:0] CTRL_CLR  = 3'd1;
  localparam logic [2:0] CTRL_LOAD = 3'd2;
  localparam logic [2:0] CTRL_INCR = 3'd3;
  localparam logic [2:0] CTRL_DECR = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SET      = 3'd1,
    S_ARMED    = 3'd2,
    S_DEFUSED  = 3'd3,
    S_EXPLODED = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [WR_W-1:0]  wrong_q, wrong_d;

  logic             timer_zero;
  logic             timer_full;
  logic             timer_one;
  logic             code_match;
  logic             tick_due;
  logic [WR_W-1:0]  wrong_inc;
  logic [REM_W-1:0] remaining;

  assign timer_zero = (timer_value == '0);
  assign timer_full = &timer_value;
  assign timer_one  = (timer_value == TIMER_WIDTH'(1));
  assign code_match = code_valid && (code_in == secret_value);
  assign tick_due   = (presc_q == PRE_LAST);
  assign wrong_inc  = wrong_q + WR_W'(1);

  assign state = state_q;

  // Remaining attempts, saturated to the 2-bit output range.
  always_comb begin
    remaining = REM_W'(WR_MAX) - REM_W'(wrong_q);
    if (remaining > REM_W'(3)) begin
      tries_left = 2'd3;
    end else begin
      tries_left = remaining[1:0];
    end
  end

  // State, prescaler and wrong-entry registers; reset forces IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      wrong_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      wrong_q <= wrong_d;
    end
  end

  // Next-state and register-control decode; clear wins in every non-IDLE state.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    wrong_d     = wrong_q;
    timer_ctrl  = CTRL_NONE;
    secret_ctrl = CTRL_NONE;
    tick        = 1'b0;

    if (state_q != S_IDLE && clear) begin
      state_d = S_IDLE;
      presc_d = '0;
      wrong_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_ctrl  = CTRL_CLR;
          secret_ctrl = CTRL_CLR;
          presc_d     = '0;
          wrong_d     = '0;
          if (start) begin
            state_d = S_SET;
          end
        end

        S_SET: begin
          if (arm && !timer_zero) begin
            secret_ctrl = CTRL_LOAD;
            state_d     = S_ARMED;
            presc_d     = '0;
            wrong_d     = '0;
          end else if (set_up && !set_down && !timer_full) begin
            timer_ctrl = CTRL_INCR;
          end else if (set_down && !set_up && !timer_zero) begin
            timer_ctrl = CTRL_DECR;
          end
        end

        S_ARMED: begin
          if (code_match) begin
            // Correct code beats a same-cycle tick: no decrement, no pulse.
            state_d = S_DEFUSED;
          end else begin
            presc_d = tick_due ? '0 : presc_q + PRE_W'(1);
            if (tick_due) begin
              timer_ctrl = CTRL_DECR;
              tick       = 1'b1;
              if (timer_one) begin
                state_d = S_EXPLODED;
              end
            end
            if (code_valid) begin
              wrong_d = wrong_inc;
              if (wrong_inc == WR_MAX) begin
                state_d = S_EXPLODED;
              end
            end
          end
        end

        S_DEFUSED, S_EXPLODED: begin
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_sequencer.sv
// Directed bench for bomb_sequencer with behavioural models of the external
// timer and secret registers driven by the DUT control codes.
module tb_bomb_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, clear, set_up, set_down, arm, code_valid;
  logic [3:0] code_in;
  logic [7:0] timer_value;
  logic [3:0] secret_value;
  logic [2:0] timer_ctrl, secret_ctrl, state;
  logic       tick;
  logic [1:0] tries_left;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit       start, clear, up, down, arm, cv;
    bit [3:0] code;
    int       st, tc, sc, tk, tr, tm;
  } vec_t;

  vec_t vq[$];

  bomb_sequencer #(
    .TIMER_WIDTH(8), .CODE_WIDTH(4), .TICK_DIV(4), .MAX_TRIES(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .set_up(set_up), .set_down(set_down), .arm(arm),
    .code_in(code_in), .code_valid(code_valid),
    .timer_value(timer_value), .secret_value(secret_value),
    .timer_ctrl(timer_ctrl), .secret_ctrl(secret_ctrl),
    .state(state), .tick(tick), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  // External timer register model.
  always @(posedge clk) begin
    case (timer_ctrl)
      3'd1: timer_value <= 8'd0;
      3'd3: timer_value <= timer_value + 8'd1;
      3'd4: timer_value <= timer_value - 8'd1;
      default: ;
    endcase
  end

  // External secret register model, loaded from code_in.
  always @(posedge clk) begin
    case (secret_ctrl)
      3'd1: secret_value <= 4'd0;
      3'd2: secret_value <= code_in;
      default: ;
    endcase
  end

  function automatic void add(bit s, bit c, bit u, bit d, bit a, bit v, bit [3:0] cd,
                              int st, int tc, int sc, int tk, int tr, int tm);
    vec_t x;
    x.start = s; x.clear = c; x.up = u; x.down = d; x.arm = a; x.cv = v; x.code = cd;
    x.st = st; x.tc = tc; x.sc = sc; x.tk = tk; x.tr = tr; x.tm = tm;
    vq.push_back(x);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t x);
    chk("state", idx, int'(state), x.st);
    chk("timer_ctrl", idx, int'(timer_ctrl), x.tc);
    chk("secret_ctrl", idx, int'(secret_ctrl), x.sc);
    chk("tick", idx, int'(tick), x.tk);
    chk("tries_left", idx, int'(tries_left), x.tr);
    chk("timer_value", idx, int'(timer_value), x.tm);
  endtask

  // Drive one vector at the falling edge, check combinational/registered outputs just after.
  task automatic step(input int idx, input vec_t x);
    @(negedge clk);
    start = x.start; clear = x.clear; set_up = x.up; set_down = x.down;
    arm = x.arm; code_valid = x.cv; code_in = x.code;
    #1;
    check_all(idx, x);
  endtask

  int split;

  initial begin
    rst = 1'b1;
    start = 0; clear = 0; set_up = 0; set_down = 0; arm = 0; code_valid = 0; code_in = 4'h0;
    timer_value = 8'h55;
    secret_value = 4'h5;

    // Reset state, SET edge cases, preset to 5, arm with 4'hA
    add(0,0,0,0,0,0,4'h0, 0,1,1,0,3,0);
    add(1,0,0,0,0,0,4'h0, 0,1,1,0,3,0);
    add(0,0,0,1,0,0,4'h0, 1,0,0,0,3,0);   // set_down at 0 -> NONE
    add(0,0,0,0,1,0,4'h0, 1,0,0,0,3,0);   // arm at 0 ignored
    for (int i = 0; i < 5; i++) add(0,0,1,0,0,0,4'h0, 1,3,0,0,3,i);
    add(0,0,1,1,0,0,4'h0, 1,0,0,0,3,5);   // both buttons -> NONE
    add(1,0,0,0,0,1,4'hA, 1,0,0,0,3,5);   // start/code ignored in SET
    add(0,0,0,0,1,0,4'hA, 1,0,2,0,3,5);   // LOAD
    add(0,0,0,0,0,0,4'h0, 2,0,0,0,3,5);
    add(0,0,0,0,0,1,4'h1, 2,0,0,0,3,5);
    add(0,0,0,0,0,1,4'h2, 2,0,0,0,2,5);
    add(0,0,0,0,0,0,4'h0, 2,4,0,1,1,5);   // first tick
    add(0,0,0,0,0,1,4'hA, 2,0,0,0,1,4);   // correct -> DEFUSED
    add(0,0,0,0,0,0,4'h0, 3,0,0,0,1,4);
    add(1,0,1,0,1,1,4'hA, 3,0,0,0,1,4);   // frozen
    add(0,1,0,0,0,0,4'h0, 3,0,0,0,1,4);
    add(0,0,0,0,0,0,4'h0, 0,1,1,0,3,4);

    // Countdown from 3 to explosion
    add(1,0,0,0,0,0,4'h0, 0,1,1,0,3,0);
    for (int i = 0; i < 3; i++) add(0,0,1,0,0,0,4'h0, 1,3,0,0,3,i);
    add(0,0,0,0,1,0,4'h5, 1,0,2,0,3,3);
    for (int t = 3; t >= 1; t--) begin
      for (int k = 0; k < 3; k++) add(0,0,0,0,0,0,4'h0, 2,0,0,0,3,t);
      add(0,0,0,0,0,0,4'h0, 2,4,0,1,3,t);
    end
    add(0,0,0,0,0,0,4'h0, 4,0,0,0,3,0);
    add(0,1,0,0,0,0,4'h0, 4,0,0,0,3,0);
    add(0,0,0,0,0,0,4'h0, 0,1,1,0,3,0);

    // Three wrong codes
    add(1,0,0,0,0,0,4'h0, 0,1,1,0,3,0);
    add(0,0,1,0,0,0,4'h0, 1,3,0,0,3,0);
    add(0,0,0,0,1,0,4'h7, 1,0,2,0,3,1);
    add(0,0,0,0,0,1,4'h1, 2,0,0,0,3,1);
    add(0,0,0,0,0,1,4'h2, 2,0,0,0,2,1);
    add(0,0,0,0,0,1,4'h3, 2,0,0,0,1,1);
    add(0,0,0,0,0,0,4'h0, 4,0,0,0,0,1);
    add(0,1,0,0,0,0,4'h0, 4,0,0,0,0,1);
    add(0,0,0,0,0,0,4'h0, 0,1,1,0,3,1);

    // Timer 1, correct code on the tick cycle
    add(1,0,0,0,0,0,4'h0, 0,1,1,0,3,0);
    add(0,0,1,0,0,0,4'h0, 1,3,0,0,3,0);
    add(0,0,0,0,1,0,4'h9, 1,0,2,0,3,1);
    for (int k = 0; k < 3; k++) add(0,0,0,0,0,0,4'h0, 2,0,0,0,3,1);
    add(0,0,0,0,0,1,4'h9, 2,0,0,0,3,1);
    add(0,0,0,0,0,0,4'h0, 3,0,0,0,3,1);
    add(0,1,0,0,0,0,4'h0, 3,0,0,0,3,1);
    add(0,0,0,0,0,0,4'h0, 0,1,1,0,3,1);

    // Wrong final attempt together with a tick
    add(1,0,0,0,0,0,4'h0, 0,1,1,0,3,0);
    for (int i = 0; i < 3; i++) add(0,0,1,0,0,0,4'h0, 1,3,0,0,3,i);
    add(0,0,0,0,1,0,4'hB, 1,0,2,0,3,3);
    add(0,0,0,0,0,1,4'h1, 2,0,0,0,3,3);
    add(0,0,0,0,0,1,4'h2, 2,0,0,0,2,3);
    add(0,0,0,0,0,0,4'h0, 2,0,0,0,1,3);
    add(0,0,0,0,0,1,4'h3, 2,4,0,1,1,3);
    add(0,0,0,0,0,0,4'h0, 4,0,0,0,0,2);
    add(0,1,0,0,0,0,4'h0, 4,0,0,0,0,2);

    // Re-arm at 3 and run partway into the countdown before a reset pulse
    add(1,0,0,0,0,0,4'h0, 0,1,1,0,3,2);
    for (int i = 0; i < 3; i++) add(0,0,1,0,0,0,4'h0, 1,3,0,0,3,i);
    add(0,0,0,0,1,0,4'h4, 1,0,2,0,3,3);
    add(0,0,0,0,0,0,4'h0, 2,0,0,0,3,3);
    add(0,0,0,0,0,0,4'h0, 2,0,0,0,3,3);
    split = vq.size();

    // After reset: resume from IDLE, set_down at 0, clear in SET and ARMED
    add(0,0,0,0,0,0,4'h0, 0,1,1,0,3,0);
    add(1,0,0,0,0,0,4'h0, 0,1,1,0,3,0);
    add(0,0,0,1,0,0,4'h0, 1,0,0,0,3,0);
    add(0,1,1,0,1,0,4'h0, 1,0,0,0,3,0);
    add(1,0,0,0,0,0,4'h0, 0,1,1,0,3,0);
    add(0,0,1,0,0,0,4'h0, 1,3,0,0,3,0);
    add(0,0,0,0,1,0,4'h2, 1,0,2,0,3,1);
    add(0,1,1,0,0,1,4'h2, 2,0,0,0,3,1);  // clear beats correct code
    add(0,0,0,0,0,0,4'h0, 0,1,1,0,3,1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < split; i++) step(i, vq[i]);

    // Asynchronous reset mid-countdown, away from any clock edge
    @(negedge clk);
    start = 0; clear = 0; set_up = 0; set_down = 0; arm = 0; code_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_state", -1, int'(state), 0);
    chk("rst_timer_ctrl", -1, int'(timer_ctrl), 1);
    chk("rst_secret_ctrl", -1, int'(secret_ctrl), 1);
    chk("rst_tick", -1, int'(tick), 0);
    chk("rst_tries_left", -1, int'(tries_left), 3);
    @(posedge clk);
    #1;
    chk("rst_timer_cleared", -1, int'(timer_value), 0);
    chk("rst_state_held", -1, int'(state), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = split; i < vq.size(); i++) step(i, vq[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so a stuck run still terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
